// File: rtl/pooling_pkg.sv
// Shared pooling definitions: default geometry, controller states and width helper.
package pooling_pkg;

  localparam int unsigned DEF_INPUT_SIZE  = 6;
  localparam int unsigned DEF_KERNEL_SIZE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int unsigned logb2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/pooling_controller_if.sv
// Source-request / pooling-datapath control bundle driven by pooling_controller.
interface pooling_controller_if
  import pooling_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE
) ();

  localparam int unsigned SW = logb2(INPUT_SIZE);
  localparam int unsigned RW = logb2(INPUT_SIZE / KERNEL_SIZE);

  logic          src_req;
  logic          src_valid;
  logic [SW-1:0] src_row;
  logic [SW-1:0] src_col;
  logic          load;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [RW-1:0] res_row;
  logic [RW-1:0] res_col;

  modport master (
    output src_req, src_row, src_col, load,
    output out_valid, out_first, out_last, res_row, res_col,
    input  src_valid
  );

  modport slave (
    input  src_req, src_row, src_col, load,
    input  out_valid, out_first, out_last, res_row, res_col,
    output src_valid
  );

endinterface

// File: rtl/pooling_window_counter.sv
// Nested kern_row -> win_col -> win_row position counter for the pooling walk.
module pooling_window_counter
  import pooling_pkg::*;
#(
  parameter  int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter  int unsigned WINDOWS     = DEF_INPUT_SIZE / DEF_KERNEL_SIZE,
  localparam int unsigned KW          = logb2(KERNEL_SIZE),
  localparam int unsigned WW          = logb2(WINDOWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [KW-1:0] kern_row,
  output logic [WW-1:0] win_col,
  output logic [WW-1:0] win_row,
  output logic          kern_last,
  output logic          pass_last
);

  logic col_last;
  logic row_last;

  assign kern_last = (kern_row == KW'(KERNEL_SIZE - 1));
  assign col_last  = (win_col == WW'(WINDOWS - 1));
  assign row_last  = (win_row == WW'(WINDOWS - 1));
  assign pass_last = kern_last & col_last & row_last;

  // Step one segment per advance, rolling kern_row into win_col into win_row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kern_row <= '0;
      win_col  <= '0;
      win_row  <= '0;
    end else if (clear) begin
      kern_row <= '0;
      win_col  <= '0;
      win_row  <= '0;
    end else if (advance) begin
      if (!kern_last) begin
        kern_row <= kern_row + KW'(1);
      end else begin
        kern_row <= '0;
        if (!col_last) begin
          win_col <= win_col + WW'(1);
        end else begin
          win_col <= '0;
          win_row <= row_last ? '0 : win_row + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pooling_controller.sv
// Sequences one feature-map pass: requests row segments window by window and
// qualifies the pooled word stream with first/last/result coordinates.
module pooling_controller
  import pooling_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  pooling_controller_if.master  ctrl
);

  localparam int unsigned WINDOWS = INPUT_SIZE / KERNEL_SIZE;
  localparam int unsigned SW      = logb2(INPUT_SIZE);
  localparam int unsigned RW      = logb2(WINDOWS);
  localparam int unsigned KW      = logb2(KERNEL_SIZE);
  localparam int unsigned DW      = logb2(KERNEL_SIZE + 1);

  pool_state_t   state;
  pool_state_t   state_nxt;
  logic [DW-1:0] drain_cnt;
  logic          seg_first;
  logic          seg_last;
  logic [RW-1:0] res_row_q;
  logic [RW-1:0] res_col_q;

  logic [KW-1:0] kern_row;
  logic [RW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          kern_last;
  logic          pass_last;

  logic          pass_start;
  logic          src_req_c;
  logic          load_c;
  logic          out_valid_c;
  logic          out_first_c;
  logic          out_last_c;

  assign pass_start = (state == IDLE) && start;

  pooling_window_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .WINDOWS     (WINDOWS)
  ) u_win_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pass_start),
    .advance   (load_c),
    .kern_row  (kern_row),
    .win_col   (win_col),
    .win_row   (win_row),
    .kern_last (kern_last),
    .pass_last (pass_last)
  );

  // Requesting while the final word of the current segment is on the bus
  // keeps the stream gapless; RUN implies segments remain to be fetched.
  assign src_req_c   = (state == RUN) && (drain_cnt <= DW'(1));
  assign load_c      = src_req_c & ctrl.src_valid;
  assign out_valid_c = (drain_cnt != '0);
  assign out_first_c = seg_first && (drain_cnt == DW'(KERNEL_SIZE));
  assign out_last_c  = seg_last && (drain_cnt == DW'(1));

  assign ctrl.src_req   = src_req_c;
  assign ctrl.load      = load_c;
  assign ctrl.src_row   = SW'(win_row) * SW'(KERNEL_SIZE) + SW'(kern_row);
  assign ctrl.src_col   = SW'(win_col) * SW'(KERNEL_SIZE);
  assign ctrl.out_valid = out_valid_c;
  assign ctrl.out_first = out_first_c;
  assign ctrl.out_last  = out_last_c;
  assign ctrl.res_row   = res_row_q;
  assign ctrl.res_col   = res_col_q;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Pass sequencing: fetch, drain the last segment, pulse done, return to idle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (load_c && pass_last) state_nxt = FLUSH;
      FLUSH:   if (out_last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Word drain counter plus per-segment tags captured at load; result
  // coordinates latch on a window's first segment so they stay put until
  // that window's last word has been presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
      seg_first <= 1'b0;
      seg_last  <= 1'b0;
      res_row_q <= '0;
      res_col_q <= '0;
    end else if (load_c) begin
      drain_cnt <= DW'(KERNEL_SIZE);
      seg_first <= (kern_row == '0);
      seg_last  <= kern_last;
      if (kern_row == '0) begin
        res_row_q <= win_row;
        res_col_q <= win_col;
      end
    end else if (drain_cnt != '0) begin
      drain_cnt <= drain_cnt - DW'(1);
    end
  end

endmodule
